// File: rtl/ps2_pkg.sv
// Shared types and Set-2 byte constants for the PS/2 scan-code decoder.
// Holds the event record, the prefix FSM states and the device-byte classifier.
package ps2_pkg;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } ps2_evt_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_PAUSE
    } ps2_state_t;

    localparam logic [7:0] PS2_E0       = 8'hE0;
    localparam logic [7:0] PS2_F0       = 8'hF0;
    localparam logic [7:0] PS2_E1       = 8'hE1;

    localparam logic [7:0] DEV_BAT_OK   = 8'hAA;
    localparam logic [7:0] DEV_ACK      = 8'hFA;
    localparam logic [7:0] DEV_ECHO     = 8'hEE;
    localparam logic [7:0] DEV_BAT_ERR  = 8'hFC;
    localparam logic [7:0] DEV_ERR_00   = 8'h00;
    localparam logic [7:0] DEV_ERR_FF   = 8'hFF;

    localparam logic [7:0] KEY_SHIFT_L  = 8'h12;
    localparam logic [7:0] KEY_SHIFT_R  = 8'h59;
    localparam logic [7:0] KEY_CTRL     = 8'h14;
    localparam logic [7:0] KEY_ALT      = 8'h11;
    localparam logic [7:0] KEY_PAUSE    = 8'h77;

    // Pause is E1 followed by seven more bytes that carry no key information.
    localparam logic [2:0] PAUSE_SKIP   = 3'd7;

    function automatic logic is_dev_byte(input logic [7:0] b);
        return (b == DEV_BAT_OK)  || (b == DEV_ACK)    || (b == DEV_ECHO) ||
               (b == DEV_BAT_ERR) || (b == DEV_ERR_00) || (b == DEV_ERR_FF);
    endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Synchronous event FIFO; write visible at the read port one cycle after push.
// Push while full is refused unless a pop happens in the same cycle.
module ps2_evt_fifo
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  ps2_evt_t push_dat,
    input  logic     pop,
    output ps2_evt_t pop_dat,
    output logic     full,
    output logic     empty
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    ps2_evt_t        mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_dat;
        end
    end

    // Storage is not reset, so mask the head while empty to present zeros.
    assign pop_dat = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Set-2 scan-code decoder: prefix FSM, modifier tracking and buffered key events.
// Latency: byte in cycle N -> event/modifiers/pulses visible in N+1; events wait in FIFO under evt_ready backpressure.
module ps2_scancode_decoder
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       code_valid,
    input  logic [7:0] code,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_break,
    output logic       mod_shift,
    output logic       mod_ctrl,
    output logic       mod_alt,
    output logic       overflow,
    output logic       dev_msg
);

    ps2_state_t state;
    ps2_state_t state_nxt;
    logic [2:0] skip_cnt;
    logic [2:0] skip_nxt;

    logic       dec_push;
    ps2_evt_t   dec_evt;
    logic       dev_det;

    logic       lshift, rshift, lctrl, rctrl, lalt, ralt;
    logic       lshift_nxt, rshift_nxt, lctrl_nxt, rctrl_nxt, lalt_nxt, ralt_nxt;

    ps2_evt_t   head_evt;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_pop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            skip_cnt <= '0;
        end else begin
            state    <= state_nxt;
            skip_cnt <= skip_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        skip_nxt  = skip_cnt;
        dec_push  = 1'b0;
        dec_evt   = '0;
        dev_det   = 1'b0;
        if (code_valid) begin
            case (state)
                ST_IDLE: begin
                    if (code == PS2_E0) begin
                        state_nxt = ST_EXT;
                    end else if (code == PS2_F0) begin
                        state_nxt = ST_BRK;
                    end else if (code == PS2_E1) begin
                        state_nxt = ST_PAUSE;
                        skip_nxt  = PAUSE_SKIP;
                    end else if (is_dev_byte(code)) begin
                        dev_det   = 1'b1;
                    end else begin
                        dec_push  = 1'b1;
                        dec_evt   = '{code: code, ext: 1'b0, brk: 1'b0};
                    end
                end
                ST_EXT: begin
                    if (is_dev_byte(code)) begin
                        dev_det   = 1'b1;
                        state_nxt = ST_IDLE;
                    end else if (code == PS2_F0) begin
                        state_nxt = ST_EXT_BRK;
                    end else if (code != PS2_E0) begin
                        dec_push  = 1'b1;
                        dec_evt   = '{code: code, ext: 1'b1, brk: 1'b0};
                        state_nxt = ST_IDLE;
                    end
                end
                ST_BRK, ST_EXT_BRK: begin
                    state_nxt = ST_IDLE;
                    if (is_dev_byte(code)) begin
                        dev_det  = 1'b1;
                    end else begin
                        dec_push = 1'b1;
                        dec_evt  = '{code: code, ext: (state == ST_EXT_BRK), brk: 1'b1};
                    end
                end
                ST_PAUSE: begin
                    // Payload bytes are opaque; only their count matters.
                    skip_nxt = skip_cnt - 3'd1;
                    if (skip_cnt == 3'd1) begin
                        dec_push  = 1'b1;
                        dec_evt   = '{code: KEY_PAUSE, ext: 1'b1, brk: 1'b0};
                        state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    skip_nxt  = '0;
                end
            endcase
        end
    end

    // Modifiers follow decoded events even when the FIFO drops them; E0 12/59 are ignored.
    always_comb begin
        lshift_nxt = lshift;
        rshift_nxt = rshift;
        lctrl_nxt  = lctrl;
        rctrl_nxt  = rctrl;
        lalt_nxt   = lalt;
        ralt_nxt   = ralt;
        if (dec_push) begin
            if (!dec_evt.ext) begin
                case (dec_evt.code)
                    KEY_SHIFT_L: lshift_nxt = !dec_evt.brk;
                    KEY_SHIFT_R: rshift_nxt = !dec_evt.brk;
                    KEY_CTRL:    lctrl_nxt  = !dec_evt.brk;
                    KEY_ALT:     lalt_nxt   = !dec_evt.brk;
                    default:     ;
                endcase
            end else begin
                case (dec_evt.code)
                    KEY_CTRL:    rctrl_nxt  = !dec_evt.brk;
                    KEY_ALT:     ralt_nxt   = !dec_evt.brk;
                    default:     ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lshift   <= 1'b0;
            rshift   <= 1'b0;
            lctrl    <= 1'b0;
            rctrl    <= 1'b0;
            lalt     <= 1'b0;
            ralt     <= 1'b0;
            overflow <= 1'b0;
            dev_msg  <= 1'b0;
        end else begin
            lshift   <= lshift_nxt;
            rshift   <= rshift_nxt;
            lctrl    <= lctrl_nxt;
            rctrl    <= rctrl_nxt;
            lalt     <= lalt_nxt;
            ralt     <= ralt_nxt;
            overflow <= dec_push && fifo_full && !fifo_pop;
            dev_msg  <= dev_det;
        end
    end

    assign fifo_pop = evt_ready && !fifo_empty;

    ps2_evt_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_evt_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (dec_push),
        .push_dat (dec_evt),
        .pop      (fifo_pop),
        .pop_dat  (head_evt),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign evt_valid = !fifo_empty;
    assign evt_code  = head_evt.code;
    assign evt_ext   = head_evt.ext;
    assign evt_break = head_evt.brk;
    assign mod_shift = lshift || rshift;
    assign mod_ctrl  = lctrl || rctrl;
    assign mod_alt   = lalt || ralt;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder: expected events queued by stimulus, popped by a monitor.
module tb_ps2_scancode_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       code_valid;
    logic [7:0] code;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_break;
    logic       mod_shift;
    logic       mod_ctrl;
    logic       mod_alt;
    logic       overflow;
    logic       dev_msg;

    int n_checks = 0;
    int n_fail   = 0;
    logic [9:0] exp_q[$];

    ps2_scancode_decoder #(.FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .code_valid (code_valid),
        .code       (code),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_code   (evt_code),
        .evt_ext    (evt_ext),
        .evt_break  (evt_break),
        .mod_shift  (mod_shift),
        .mod_ctrl   (mod_ctrl),
        .mod_alt    (mod_alt),
        .overflow   (overflow),
        .dev_msg    (dev_msg)
    );

    always #5 clk = ~clk;

    // Handshake seen at the negedge completes at the following posedge.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && evt_valid && evt_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL evt_unexpected: got code=%h ext=%b brk=%b, required no event",
                         evt_code, evt_ext, evt_break);
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                if ({evt_code, evt_ext, evt_break} !== e) begin
                    n_fail++;
                    $display("FAIL evt_data: got code=%h ext=%b brk=%b, required code=%h ext=%b brk=%b",
                             evt_code, evt_ext, evt_break, e[9:2], e[1], e[0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic expect_evt(input logic [7:0] c, input logic x, input logic b);
        exp_q.push_back({c, x, b});
    endtask

    // Caller sits at posedge+1; returns at posedge+1 of the cycle that sampled the byte.
    task automatic send(input logic [7:0] b);
        code_valid = 1'b1;
        code       = b;
        @(posedge clk);
        #1;
        code_valid = 1'b0;
        code       = 8'h00;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 64 && (exp_q.size() != 0 || evt_valid); i++) begin
            @(posedge clk);
            #1;
        end
        chk(name, exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        code_valid = 1'b0;
        code       = 8'h00;
        evt_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_evt_valid", evt_valid, 0);
        chk("rst_evt_fields", {evt_code, evt_ext, evt_break}, 0);
        chk("rst_mods", {mod_shift, mod_ctrl, mod_alt}, 0);
        chk("rst_pulses", {overflow, dev_msg}, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Make then break A
        expect_evt(8'h1C, 1'b0, 1'b0);
        send(8'h1C);
        chk("make_a_latency", evt_valid, 1);
        send(8'hF0);
        expect_evt(8'h1C, 1'b0, 1'b1);
        send(8'h1C);
        chk("break_a_latency", evt_valid, 1);
        drain("drain_a");

        // Extended arrow and control modifiers
        send(8'hE0);
        expect_evt(8'h75, 1'b1, 1'b0);
        send(8'h75);
        chk("ext_arrow_ctrl", mod_ctrl, 0);
        expect_evt(8'h14, 1'b0, 1'b0);
        send(8'h14);
        chk("lctrl_make", mod_ctrl, 1);
        send(8'hE0);
        expect_evt(8'h14, 1'b1, 1'b0);
        send(8'h14);
        send(8'hE0);
        send(8'hF0);
        expect_evt(8'h14, 1'b1, 1'b1);
        send(8'h14);
        chk("rctrl_break_lctrl_held", mod_ctrl, 1);
        send(8'hF0);
        expect_evt(8'h14, 1'b0, 1'b1);
        send(8'h14);
        chk("lctrl_break", mod_ctrl, 0);

        // Fake shift leaves shift alone, real right shift sets and clears it
        send(8'hE0);
        expect_evt(8'h12, 1'b1, 1'b0);
        send(8'h12);
        chk("fake_shift", mod_shift, 0);
        expect_evt(8'h59, 1'b0, 1'b0);
        send(8'h59);
        chk("rshift_make", mod_shift, 1);
        send(8'hF0);
        expect_evt(8'h59, 1'b0, 1'b1);
        send(8'h59);
        chk("rshift_break", mod_shift, 0);
        expect_evt(8'h11, 1'b0, 1'b0);
        send(8'h11);
        chk("lalt_make", mod_alt, 1);
        send(8'hF0);
        expect_evt(8'h11, 1'b0, 1'b1);
        send(8'h11);
        chk("lalt_break", mod_alt, 0);
        drain("drain_mods");

        // Pause: eight bytes yield a single extended 77 make
        expect_evt(8'h77, 1'b1, 1'b0);
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0);
        chk("pause_not_early", evt_valid, 0);
        send(8'h77);
        chk("pause_event", evt_valid, 1);
        chk("pause_mods", {mod_shift, mod_ctrl, mod_alt}, 0);
        drain("drain_pause");

        // Overflow with a stalled consumer, then full with push and pop together
        evt_ready = 1'b0;
        expect_evt(8'h15, 1'b0, 1'b0);
        send(8'h15);
        expect_evt(8'h1D, 1'b0, 1'b0);
        send(8'h1D);
        expect_evt(8'h24, 1'b0, 1'b0);
        send(8'h24);
        expect_evt(8'h2D, 1'b0, 1'b0);
        send(8'h2D);
        chk("ovf_not_yet", overflow, 0);
        send(8'h2C);
        chk("ovf_pulse", overflow, 1);
        chk("ovf_head_stable", {evt_valid, evt_code}, {1'b1, 8'h15});
        evt_ready = 1'b1;
        expect_evt(8'h2B, 1'b0, 1'b0);
        send(8'h2B);
        chk("full_push_pop_no_ovf", overflow, 0);
        drain("drain_ovf");

        // Device bytes, including one that aborts a break prefix
        send(8'hAA);
        chk("dev_msg_aa", dev_msg, 1);
        @(posedge clk);
        #1;
        chk("dev_msg_one_cycle", dev_msg, 0);
        send(8'hF0);
        send(8'hFA);
        chk("dev_msg_abort", dev_msg, 1);
        expect_evt(8'h1C, 1'b0, 1'b0);
        send(8'h1C);
        chk("abort_then_make", evt_valid, 1);
        drain("drain_dev");

        // Reset in the middle of an E0 prefix
        expect_evt(8'h12, 1'b0, 1'b0);
        send(8'h12);
        chk("lshift_before_rst", mod_shift, 1);
        send(8'hE0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_mid_empty", evt_valid, 0);
        chk("rst_mid_mods", mod_shift, 0);
        expect_evt(8'h1C, 1'b0, 1'b0);
        send(8'h1C);
        chk("rst_mid_make", evt_valid, 1);
        drain("drain_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_scancode_decoder.md
# ps2_scancode_decoder

Consumes the 8-bit scan-code bytes produced by the PS/2 keyboard receiver, already synchronised to the system clock, and interprets Set-2 prefix sequences (E0, F0, E1 Pause). Produces one key event per physical make or break and tracks live modifier state. Events are buffered in a small FIFO with a valid/ready handshake toward the keyboard consumer (terminal, debug UART, game logic).

## Interface
- `FIFO_DEPTH`, 4, event FIFO entries; power of two, ≥2.
- `clk`  in  1  system clock.
- `rst_n`  in  1  synchronous reset, active low.
- `code_valid`  in  1  one-cycle strobe: `code` holds a new received byte.
- `code`  in  8  received scan-code byte.
- `evt_valid`  out  1  FIFO head holds an event.
- `evt_ready`  in  1  consumer accepts the head event this cycle.
- `evt_code`  out  8  base scan code of the head event.
- `evt_ext`  out  1  head event was E0-prefixed, or is Pause.
- `evt_break`  out  1  1 = key release, 0 = key press.
- `mod_shift`  out  1  LShift (12) or RShift (59) held.
- `mod_ctrl`  out  1  LCtrl (14) or RCtrl (E0 14) held.
- `mod_alt`  out  1  LAlt (11) or RAlt (E0 11) held.
- `overflow`  out  1  one-cycle pulse: an event was dropped because the FIFO was full.
- `dev_msg`  out  1  one-cycle pulse: a device byte (AA, FA, EE, FC, 00, FF) arrived and was discarded.

## Operation
- FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen), PAUSE (skipping).
- IDLE:
  - E0 → EXT.
  - F0 → BRK.
  - E1 → PAUSE with skip counter = 7.
  - Device byte → `dev_msg`, stay.
  - Other byte b → push {b, ext=0, brk=0}.
- EXT:
  - F0 → EXT_BRK.
  - E0 → stay.
  - Other byte b → push {b, 1, 0}, → IDLE.
- BRK:
  - Byte b → push {b, 0, 1}, → IDLE.
- EXT_BRK:
  - Byte b → push {b, 1, 1}, → IDLE.
- In BRK, EXT_BRK and EXT, a device byte aborts the prefix: `dev_msg`, → IDLE, no push.
- PAUSE:
  - Each `code_valid` decrements the counter.
  - At the 7th byte, push {77, ext=1, brk=0} and → IDLE.
  - Byte contents are ignored; no break event is generated for Pause.
- Modifiers:
  - Internal state LShift, RShift, LCtrl, RCtrl, LAlt, RAlt, each set on make and cleared on break.
  - Updated on every decoded make or break, even if the FIFO push is dropped.
  - E0 12 and E0 59 (fake shifts) produce events but do not touch the modifiers.
- FIFO:
  - Full and push without pop → entry dropped, `overflow` pulses.
  - Pop with `evt_valid && evt_ready`.
  - Full with simultaneous push and pop → both happen, no overflow.
  - Empty with simultaneous push and pop → impossible (`evt_valid`=0); the push is stored.
- `code_valid` is ignored when not asserted; state never changes without it.

## Timing
- Reset (`rst_n`=0 at a clk edge):
  - FSM → IDLE, skip counter 0.
  - FIFO empty; all modifiers 0.
  - `evt_valid`=0, `overflow`=0, `dev_msg`=0.
  - `evt_code`/`evt_ext`/`evt_break` read 0.
  - Reset mid-sequence discards the partial prefix.
- Latency:
  - `code_valid` in cycle N → FIFO write at the end of N → `evt_valid`=1 in N+1 (empty FIFO).
  - Modifier outputs update in N+1.
  - `overflow` and `dev_msg` pulse in N+1.
- `evt_*` are stable while `evt_valid && !evt_ready`.
- Back-to-back `code_valid` in consecutive cycles is supported.
- Full throughput: one byte per cycle in, one event per cycle out.
- Pointers are log2(FIFO_DEPTH) bits plus one wrap bit. Full = MSBs differ and LSBs equal; wrap-around is natural.

## Structure
- Package `ps2_pkg` holds:
  - `ps2_evt_t` struct {code[7:0], ext, brk}.
  - FSM state enum.
  - Byte constants: E0, F0, E1, device-byte codes, modifier codes 12/59/14/11.
- Sub-module `ps2_evt_fifo`: generic synchronous FIFO of `ps2_evt_t`, parameter `FIFO_DEPTH`, with push/pop/full/empty.
- Decoder FSM and modifier logic live in the top module.

## Test plan
- Make then break A: bytes 1C, F0 1C, `evt_ready`=1 → events {1C,0,0} then {1C,0,1}; each `evt_valid` one cycle after the final byte.
- Extended arrow with modifiers: bytes E0 75, 14, E0 14, E0 F0 14 → {75,1,0}; `mod_ctrl` rises after byte 14 and stays 1 after E0 F0 14 (LCtrl still held); then F0 14 → `mod_ctrl`=0.
- Pause: bytes E1 14 77 E1 F0 14 F0 77 → exactly one event {77,1,0}; modifiers unchanged.
- Overflow, `FIFO_DEPTH`=4, `evt_ready`=0: five makes 15,1D,24,2D,2C → 4 entries; `overflow` pulses on the 5th. Then `evt_ready`=1 → 15,1D,24,2D in order.
- Device bytes and abort: AA → `dev_msg`, no event; F0 FA 1C → `dev_msg` on FA, then event {1C,0,0} (make, not break).
- Reset mid-prefix: E0, then `rst_n` low for 1 cycle, then 1C → {1C,0,0}; FIFO was empty after reset.
